mips_avalon_arbiter: RTL

Two-master, one-slave Avalon-MM arbiter that shares the single memory slave (mips_avalon_slave) between master 0 (program loader / test master) and master 1 (mips_CPU_bus).
- Replaces the ad-hoc loading/CPU mux.
- Grants one master at a time and holds the grant until that transaction completes.
- Forwards waitrequest, readdata and response to the granted master only.
- Aborts a transaction with SLAVEERROR if the slave stalls past a timeout.

---
 rtl/mips_avalon_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mips_avalon_arbiter.sv
// Two-master / one-slave Avalon-MM arbiter: one owner at a time, grant held until the
// transfer completes, with an optional slave-stall timeout that aborts with SLAVEERROR.
module mips_avalon_arbiter #(
  parameter int          PRIORITY_MODE  = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic [3:0]  m0_byteenable,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic [1:0]  m0_response,
  input  logic [31:0] m1_address,
  input  logic [3:0]  m1_byteenable,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [1:0]  m1_response,
  output logic [31:0] s_address,
  output logic [3:0]  s_byteenable,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  input  logic [1:0]  s_response,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t        state, state_nx;
  logic          last_grant, last_grant_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          req0, req1, sel, req_sel, abort;
  logic          g_waitrequest;
  logic [31:0]   g_readdata;
  logic [1:0]    g_response;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign sel     = (state == GRANT1);
  assign req_sel = sel ? req1 : req0;
  assign grant   = {state == GRANT1, state == GRANT0};

  // Abort only while the owner still requests; a withdrawn request just drops the grant.
  assign abort = (state != IDLE) && req_sel && s_waitrequest && (TIMEOUT_CYCLES != 0) &&
                 (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      last_grant  <= last_grant_nx;
      cnt         <= cnt_nx;
      timeout_err <= abort;
    end
  end

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    cnt_nx        = cnt;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (req0 && (!req1 || PRIORITY_MODE != 0 || last_grant)) begin
          state_nx      = GRANT0;
          last_grant_nx = 1'b0;
        end else if (req1) begin
          state_nx      = GRANT1;
          last_grant_nx = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        if (!req_sel || !s_waitrequest || abort) state_nx = IDLE;
        else                                     cnt_nx   = cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_address      = '0;
    s_byteenable   = '0;
    s_writedata    = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    m0_waitrequest = 1'b1;
    m0_readdata    = '0;
    m0_response    = 2'b00;
    m1_waitrequest = 1'b1;
    m1_readdata    = '0;
    m1_response    = 2'b00;
    g_waitrequest  = s_waitrequest;
    g_readdata     = s_readdata;
    g_response     = s_response;

    if (state != IDLE) begin
      s_address    = sel ? m1_address    : m0_address;
      s_byteenable = sel ? m1_byteenable : m0_byteenable;
      s_writedata  = sel ? m1_writedata  : m0_writedata;
      s_write      = sel ? m1_write      : m0_write;
      s_read       = sel ? (m1_read & ~m1_write) : (m0_read & ~m0_write);
      if (abort) begin
        s_read        = 1'b0;
        s_write       = 1'b0;
        g_waitrequest = 1'b0;
        g_readdata    = '0;
        g_response    = 2'b10;
      end
      if (sel) begin
        m1_waitrequest = g_waitrequest;
        m1_readdata    = g_readdata;
        m1_response    = g_response;
      end else begin
        m0_waitrequest = g_waitrequest;
        m0_readdata    = g_readdata;
        m0_response    = g_response;
      end
    end

    if (reset) begin
      s_read         = 1'b0;
      s_write        = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
    end
  end

endmodule
